seg7_game_ctrl: RTL and testbench



---
 rtl/seg7_game_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/seg7_game_ctrl.sv | 129 ++++++++++++
 tb/tb_seg7_game_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_game_pkg.sv
// Shared definitions for the factorization-board game controller.
// State codes are consumed directly by the 7-segment digit decoders.
package seg7_game_pkg;

  localparam logic [3:0] ST_READY    = 4'b0010;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [3:0] {
    S_READY    = ST_READY,
    S_QUESTION = ST_QUESTION,
    S_INPUT    = ST_INPUT
  } game_state_t;

  // Decimal digit increment with wrap from DIGIT_MAX back to 0
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, counter-based
// debounce and a registered single-cycle pulse on each debounced rise.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a level change only after it has persisted DEB_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One registered pulse per debounced rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/seg7_game_ctrl.sv
// Game-flow controller: READY -> QUESTION -> INPUT sequencing, question
// digit capture, candidate stepping and confirmed-selection strobe.
// Optional build macro: INPUT_TIMEOUT_EN adds an idle timeout in INPUT.
module seg7_game_ctrl
  import seg7_game_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 500000,
  parameter int unsigned QUE_HOLD       = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_NEXT,
  input  logic       BTN_OK,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] DIN,
  output logic       SEL_VALID,
  output logic [3:0] SEL_DIN
);

  localparam int unsigned HW = (QUE_HOLD > 1) ? $clog2(QUE_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(QUE_HOLD - 1);

  // Reject zero-length configurations at elaboration
  if (DEB_CYCLES == 0 || QUE_HOLD == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("seg7_game_ctrl: DEB_CYCLES, QUE_HOLD and TIMEOUT_CYCLES must be >= 1");
  end

  game_state_t   state;
  logic [3:0]    qcnt;
  logic [HW-1:0] hold;
  logic          next_p;
  logic          ok_p;

`ifdef INPUT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle;
`endif

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk   (CLK),
    .rst   (RST),
    .btn   (BTN_NEXT),
    .press (next_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ok (
    .clk   (CLK),
    .rst   (RST),
    .btn   (BTN_OK),
    .press (ok_p)
  );

  assign STATE = state;

  // Free-running modulo-10 source for the question digit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      qcnt <= 4'd0;
    end else if (qcnt == DIGIT_MAX) begin
      qcnt <= 4'd0;
    end else begin
      qcnt <= qcnt + 4'd1;
    end
  end

  // Game FSM with registered outputs; OK has priority over NEXT
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_READY;
      QUE       <= 4'd0;
      DIN       <= 4'd0;
      SEL_VALID <= 1'b0;
      SEL_DIN   <= 4'd0;
      hold      <= '0;
`ifdef INPUT_TIMEOUT_EN
      idle      <= '0;
`endif
    end else begin
      SEL_VALID <= 1'b0;
      case (state)
        S_READY: begin
          if (ok_p) begin
            QUE   <= qcnt;
            hold  <= '0;
            state <= S_QUESTION;
          end
        end
        S_QUESTION: begin
          if (hold == HOLD_LAST) begin
            DIN   <= 4'd0;
            state <= S_INPUT;
`ifdef INPUT_TIMEOUT_EN
            idle  <= '0;
`endif
          end else begin
            hold <= hold + HW'(1);
          end
        end
        S_INPUT: begin
`ifdef INPUT_TIMEOUT_EN
          if (ok_p || next_p) begin
            idle <= '0;
          end else if (idle == IDLE_LAST) begin
            state <= S_READY;
          end else begin
            idle <= idle + TW'(1);
          end
`endif
          if (ok_p) begin
            if (DIN != 4'd0) begin
              SEL_VALID <= 1'b1;
              SEL_DIN   <= DIN;
              state     <= S_READY;
            end
          end else if (next_p) begin
            DIN <= digit_inc(DIN);
          end
        end
        default: begin
          state <= S_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_game_ctrl.sv
// Self-checking bench for seg7_game_ctrl with a transaction-level model
// of the game and a scoreboard for confirmed selections.
module tb_seg7_game_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int TMO  = 20;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_NEXT;
  logic       BTN_OK;
  logic [3:0] STATE;
  logic [3:0] QUE;
  logic [3:0] DIN;
  logic       SEL_VALID;
  logic [3:0] SEL_DIN;

  int n_pass  = 0;
  int n_total = 0;
  int exp_sel[$];
  int m_din;
  int cyc;
  logic prev_sv;

  seg7_game_ctrl #(
    .DEB_CYCLES     (DEB),
    .QUE_HOLD       (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_NEXT  (BTN_NEXT),
    .BTN_OK    (BTN_OK),
    .STATE     (STATE),
    .QUE       (QUE),
    .DIN       (DIN),
    .SEL_VALID (SEL_VALID),
    .SEL_DIN   (SEL_DIN)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; mod 10 gives the expected question digit
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected selection
  always @(negedge CLK) begin
    if (RST) begin
      prev_sv = 1'b0;
    end else begin
      if (SEL_VALID) begin
        chk("sel_one_cycle", int'(prev_sv), 0);
        chk("sel_state_ready", int'(STATE), 2);
        if (exp_sel.size() == 0) chk("sel_unexpected", int'(SEL_VALID), 0);
        else chk("sel_din", int'(SEL_DIN), exp_sel.pop_front());
      end
      prev_sv = SEL_VALID;
    end
  end

  // Clean press: held long enough to debounce, then released and settled
  task automatic press(input logic nxt, input logic ok);
    BTN_NEXT = nxt;
    BTN_OK   = ok;
    repeat (DEB + 2) @(negedge CLK);
    BTN_NEXT = 1'b0;
    BTN_OK   = 1'b0;
    repeat (DEB + 3) @(negedge CLK);
  endtask

  // OK from READY with exact latency, question capture and hold length
  task automatic ok_from_ready(input bit glitch);
    int eq;
    if (glitch) begin
      BTN_OK = 1'b1;
      repeat (3) @(negedge CLK);
      BTN_OK = 1'b0;
      repeat (2) @(negedge CLK);
      chk("glitch_no_press", int'(STATE), 2);
    end
    BTN_OK = 1'b1;
    repeat (DEB + 3) @(negedge CLK);
    chk("ready_before_effect", int'(STATE), 2);
    eq = cyc % 10;
    @(negedge CLK);
    chk("enter_question", int'(STATE), 3);
    chk("que_latch", int'(QUE), eq);
    BTN_OK = 1'b0;
    for (int i = 1; i < HOLD; i++) begin
      @(negedge CLK);
      chk("question_hold", int'(STATE), 3);
    end
    @(negedge CLK);
    chk("enter_input", int'(STATE), 4);
    chk("din_cleared", int'(DIN), 0);
    m_din = 0;
  endtask

  task automatic do_round(input int r);
    int  k;
    int  nn;
    bit  both;
    k = (r == 0) ? 0 : int'($urandom_range(0, 2));
    repeat (k) begin
      press(1'b1, 1'b0);
      chk("ready_ignores_next", int'(STATE), 2);
      chk("ready_din_held", int'(DIN), m_din);
    end
    ok_from_ready(r == 0 || $urandom_range(0, 3) == 0);
    if (r == 1 || $urandom_range(0, 2) == 0) begin
      press(1'($urandom_range(0, 1)), 1'b1);
      chk("zero_ok_state", int'(STATE), 4);
      chk("zero_ok_din", int'(DIN), 0);
    end
    nn = (r == 0) ? 11 : (r == 1) ? 3 : (r == 2) ? 5 : int'($urandom_range(0, 12));
    repeat (nn) begin
      press(1'b1, 1'b0);
      m_din = (m_din + 1) % 10;
      chk("next_step", int'(DIN), m_din);
      chk("input_state", int'(STATE), 4);
    end
    if (m_din == 0) begin
      press(1'b1, 1'b0);
      m_din = 1;
      chk("next_step", int'(DIN), m_din);
    end
    both = (r == 2) || ($urandom_range(0, 1) == 1);
    exp_sel.push_back(m_din);
    press(both, 1'b1);
    chk("confirm_state", int'(STATE), 2);
    chk("din_kept", int'(DIN), m_din);
    chk("sel_drained", exp_sel.size(), 0);
  endtask

  initial begin
    RST      = 1'b1;
    BTN_NEXT = 1'b0;
    BTN_OK   = 1'b0;
    m_din    = 0;
    repeat (2) @(negedge CLK);
    chk("rst_state", int'(STATE), 2);
    chk("rst_que", int'(QUE), 0);
    chk("rst_din", int'(DIN), 0);
    chk("rst_sel_valid", int'(SEL_VALID), 0);
    chk("rst_sel_din", int'(SEL_DIN), 0);
    RST = 1'b0;
    @(negedge CLK);

    for (int r = 0; r < 10; r++) do_round(r);

    // Reset in QUESTION clears everything without waiting for a clock
    BTN_OK = 1'b1;
    repeat (DEB + 4) @(negedge CLK);
    chk("pre_rst_question", int'(STATE), 3);
    repeat (3) @(negedge CLK);
    BTN_OK = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("async_rst_state", int'(STATE), 2);
    chk("async_rst_que", int'(QUE), 0);
    chk("async_rst_din", int'(DIN), 0);
    chk("async_rst_sel_din", int'(SEL_DIN), 0);
    @(negedge CLK);
    RST   = 1'b0;
    m_din = 0;
    @(negedge CLK);

    ok_from_ready(1'b0);
`ifdef INPUT_TIMEOUT_EN
    for (int i = 1; i < TMO; i++) begin
      @(negedge CLK);
      chk("idle_before_timeout", int'(STATE), 4);
    end
    @(negedge CLK);
    chk("timeout_to_ready", int'(STATE), 2);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      chk("no_timeout", int'(STATE), 4);
    end
`endif
    repeat (3) @(negedge CLK);
    chk("sel_queue_empty", exp_sel.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within bound");
    $fatal(1, "watchdog expired");
  end

endmodule
